// File: rtl/trigger_pulse_pkg.sv
// trigger_pulse_pkg: channel state encoding and default widths shared by the trigger pulse bank
package trigger_pulse_pkg;
  localparam int NCH_D   = 4;
  localparam int DEL_W_D = 21;
  localparam int DUR_W_D = 11;
  localparam int REP_W_D = 8;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_DELAY,
    ST_ACTIVE,
    ST_GAP,
    ST_DONE
  } ch_state_t;
  function automatic logic is_running(input ch_state_t s);
    return s == ST_DELAY || s == ST_ACTIVE || s == ST_GAP;
  endfunction
endpackage

// File: rtl/trigger_pulse_channel.sv
// trigger_pulse_channel: one armed/fired pulse-train generator with its own configuration shadows
module trigger_pulse_channel
  import trigger_pulse_pkg::*;
#(
  parameter int DEL_W = DEL_W_D,
  parameter int DUR_W = DUR_W_D,
  parameter int REP_W = REP_W_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hard_stop,
  input  logic             arm,
  input  logic             fire,
  input  logic             rest_level,
  input  logic             cfg_wr,
  input  logic             cfg_en,
  input  logic [DEL_W-1:0] cfg_delay,
  input  logic [DUR_W-1:0] cfg_dur,
  input  logic [DUR_W-1:0] cfg_gap,
  input  logic [REP_W-1:0] cfg_npulse,
  output logic             trig_out,
  output logic             ch_done,
  output logic             running
);
  localparam int CW = DEL_W > DUR_W ? DEL_W : DUR_W;
  ch_state_t st, st_n;
  logic [CW-1:0] cnt, cnt_n, dur_ld, gap_ld;
  logic [REP_W-1:0] pcnt, pcnt_n;
  logic done_n, en_s, writable;
  logic [DEL_W-1:0] delay_s;
  logic [DUR_W-1:0] dur_s, gap_s;
  logic [REP_W-1:0] np_s;
  assign writable = st == ST_IDLE || st == ST_DONE;
  assign running  = is_running(st);
  // One counter is reused for delay, pulse width and gap; each load is "cycles left after this one".
  assign dur_ld = dur_s == '0 ? '0 : CW'(dur_s) - CW'(1);
  assign gap_ld = gap_s == '0 ? '0 : CW'(gap_s) - CW'(1);
  always_comb begin
    st_n   = st;
    cnt_n  = cnt;
    pcnt_n = pcnt;
    done_n = ch_done;
    case (st)
      ST_IDLE, ST_DONE: begin
        st_n   = en_s && arm ? ST_ARMED : st;
        done_n = en_s && arm ? 1'b0 : ch_done;
      end
      ST_ARMED: if (arm && fire) begin
        pcnt_n = np_s == '0 ? REP_W'(1) : np_s;
        st_n   = delay_s == '0 ? ST_ACTIVE : ST_DELAY;
        cnt_n  = delay_s == '0 ? dur_ld : CW'(delay_s) - CW'(1);
      end
      ST_DELAY: begin
        st_n  = cnt == '0 ? ST_ACTIVE : ST_DELAY;
        cnt_n = cnt == '0 ? dur_ld : cnt - CW'(1);
      end
      ST_ACTIVE: if (cnt != '0) cnt_n = cnt - CW'(1);
      else begin
        pcnt_n = pcnt == '0 ? '0 : pcnt - REP_W'(1);
        if (pcnt <= REP_W'(1)) begin
          st_n   = ST_DONE;
          done_n = 1'b1;
        end else begin
          st_n  = gap_s == '0 ? ST_ACTIVE : ST_GAP;
          cnt_n = gap_s == '0 ? dur_ld : gap_ld;
        end
      end
      ST_GAP: begin
        st_n  = cnt == '0 ? ST_ACTIVE : ST_GAP;
        cnt_n = cnt == '0 ? dur_ld : cnt - CW'(1);
      end
      default: st_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (hard_stop || !rst) begin
      st       <= ST_IDLE;
      cnt      <= '0;
      pcnt     <= '0;
      trig_out <= rest_level;
      ch_done  <= 1'b1;
    end else begin
      st       <= st_n;
      cnt      <= cnt_n;
      pcnt     <= pcnt_n;
      trig_out <= st_n == ST_ACTIVE && dur_s != '0 ? ~rest_level : rest_level;
      ch_done  <= done_n;
    end
  end
  // hard_stop outranks rst so an abort never wipes the configuration.
  always_ff @(posedge clk) begin
    if (!hard_stop && !rst) begin
      en_s    <= 1'b0;
      delay_s <= '0;
      dur_s   <= '0;
      gap_s   <= '0;
      np_s    <= '0;
    end else if (!hard_stop && cfg_wr && writable) begin
      en_s    <= cfg_en;
      delay_s <= cfg_delay;
      dur_s   <= cfg_dur;
      gap_s   <= cfg_gap;
      np_s    <= cfg_npulse;
    end
  end
endmodule

// File: rtl/trigger_pulse_bank.sv
// trigger_pulse_bank: NCH independent trigger channels with shared arm/fire/abort and config decode
module trigger_pulse_bank
  import trigger_pulse_pkg::*;
#(
  parameter int NCH   = NCH_D,
  parameter int DEL_W = DEL_W_D,
  parameter int DUR_W = DUR_W_D,
  parameter int REP_W = REP_W_D,
  localparam int CH_W = NCH > 1 ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hard_stop,
  input  logic             arm,
  input  logic             fire,
  input  logic [NCH-1:0]   rest_level,
  input  logic             cfg_wr,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic             cfg_en,
  input  logic [DEL_W-1:0] cfg_delay,
  input  logic [DUR_W-1:0] cfg_dur,
  input  logic [DUR_W-1:0] cfg_gap,
  input  logic [REP_W-1:0] cfg_npulse,
  output logic [NCH-1:0]   trig_out,
  output logic [NCH-1:0]   ch_done,
  output logic             busy
);
  logic [NCH-1:0] running;
  assign busy = |running;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    trigger_pulse_channel #(
      .DEL_W(DEL_W),
      .DUR_W(DUR_W),
      .REP_W(REP_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .hard_stop  (hard_stop),
      .arm        (arm),
      .fire       (fire),
      .rest_level (rest_level[i]),
      .cfg_wr     (cfg_wr && cfg_ch == CH_W'(i)),
      .cfg_en     (cfg_en),
      .cfg_delay  (cfg_delay),
      .cfg_dur    (cfg_dur),
      .cfg_gap    (cfg_gap),
      .cfg_npulse (cfg_npulse),
      .trig_out   (trig_out[i]),
      .ch_done    (ch_done[i]),
      .running    (running[i])
    );
  end
endmodule

// File: tb/tb_trigger_pulse_bank.sv
// tb_trigger_pulse_bank: directed scenarios with a cycle-tagged scoreboard checked by a negedge monitor
module tb_trigger_pulse_bank;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, hard_stop, arm, fire, cfg_wr, cfg_wr3, cfg_en, busy, busy3;
  logic [3:0] rest_level, trig_out, ch_done;
  logic [2:0] trig_out3, ch_done3;
  logic [1:0] cfg_ch;
  logic [20:0] cfg_delay;
  logic [10:0] cfg_dur, cfg_gap;
  logic [7:0] cfg_npulse;
  trigger_pulse_bank dut (
    .clk(clk), .rst(rst), .hard_stop(hard_stop), .arm(arm), .fire(fire),
    .rest_level(rest_level), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_en(cfg_en),
    .cfg_delay(cfg_delay), .cfg_dur(cfg_dur), .cfg_gap(cfg_gap), .cfg_npulse(cfg_npulse),
    .trig_out(trig_out), .ch_done(ch_done), .busy(busy)
  );
  trigger_pulse_bank #(.NCH(3)) dut3 (
    .clk(clk), .rst(rst), .hard_stop(hard_stop), .arm(arm), .fire(fire),
    .rest_level(rest_level[2:0]), .cfg_wr(cfg_wr3), .cfg_ch(cfg_ch), .cfg_en(cfg_en),
    .cfg_delay(cfg_delay), .cfg_dur(cfg_dur), .cfg_gap(cfg_gap), .cfg_npulse(cfg_npulse),
    .trig_out(trig_out3), .ch_done(ch_done3), .busy(busy3)
  );
  typedef struct {
    int         c;
    int         k;
    logic [3:0] m;
    logic [3:0] v;
    string      nm;
  } exp_t;
  exp_t q[$];
  int cyc = 0, checks = 0, errors = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic sb_push(input int c, input int k, input logic [3:0] m, input logic [3:0] v, input string nm);
    q.push_back('{c, k, m, v, nm});
  endtask
  // kind: 0 trig_out, 1 ch_done, 2 busy, 3 ch_done of the 3-channel bank, 4 busy of the 3-channel bank
  always @(negedge clk) begin
    logic [3:0] act;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].c <= cyc) begin
        act = q[i].k == 0 ? trig_out : q[i].k == 1 ? ch_done : q[i].k == 2 ? {3'b0, busy} :
              q[i].k == 3 ? {1'b0, ch_done3} : {3'b0, busy3};
        checks++;
        if (q[i].c < cyc || (act & q[i].m) !== (q[i].v & q[i].m)) begin
          errors++;
          $display("FAIL %s @cycle %0d: got %b want %b (mask %b)", q[i].nm, q[i].c, act & q[i].m, q[i].v & q[i].m, q[i].m);
        end
        q.delete(i);
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic cfg(input int ch, input logic en, input int d, input int du, input int g, input int n);
    cfg_ch = 2'(ch); cfg_en = en; cfg_delay = 21'(d); cfg_dur = 11'(du); cfg_gap = 11'(g); cfg_npulse = 8'(n);
    cfg_wr = 1'b1;
    tick;
    cfg_wr = 1'b0;
  endtask
  initial begin
    int t, t2;
    logic [11:0] p;
    rst = 1'b0; hard_stop = 1'b0; arm = 1'b0; fire = 1'b0; rest_level = 4'b0100;
    cfg_wr = 1'b0; cfg_wr3 = 1'b0; cfg_ch = '0; cfg_en = 1'b0;
    cfg_delay = '0; cfg_dur = '0; cfg_gap = '0; cfg_npulse = '0;
    repeat (3) tick;
    sb_push(cyc, 0, 4'hF, 4'b0100, "rst_trig");
    sb_push(cyc, 1, 4'hF, 4'hF, "rst_done");
    sb_push(cyc, 2, 4'h1, 4'h0, "rst_busy");
    sb_push(cyc, 3, 4'h7, 4'h7, "rst_done3");
    rst = 1'b1;
    tick;
    // ch0: delay 3, dur 5, single pulse
    cfg(0, 1, 3, 5, 0, 1);
    arm = 1'b1;
    tick;
    sb_push(cyc, 1, 4'h1, 4'h0, "s1_armed_done");
    fire = 1'b1; t = cyc;
    for (int k = 1; k <= 10; k++) begin
      sb_push(t + k, 0, 4'h1, (k >= 4 && k <= 8) ? 4'h1 : 4'h0, "s1_trig");
      sb_push(t + k, 1, 4'h1, k >= 9 ? 4'h1 : 4'h0, "s1_done");
      sb_push(t + k, 2, 4'h1, k <= 8 ? 4'h1 : 4'h0, "s1_busy");
    end
    tick;
    arm = 1'b0; fire = 1'b0;
    repeat (11) tick;
    // ch1: delay 0, dur 2, gap 3, three pulses
    cfg(1, 1, 0, 2, 3, 3);
    arm = 1'b1;
    tick;
    fire = 1'b1; t = cyc;
    p = 12'b110001100011;
    for (int k = 1; k <= 13; k++) begin
      sb_push(t + k, 0, 4'h2, (k <= 12 && p[12-k]) ? 4'h2 : 4'h0, "s2_trig");
      if (k >= 12) sb_push(t + k, 1, 4'h2, k == 13 ? 4'h2 : 4'h0, "s2_done");
    end
    tick;
    arm = 1'b0; fire = 1'b0;
    repeat (14) tick;
    // ch3: arm+fire together from IDLE only arms; a later fire runs
    cfg(0, 0, 0, 0, 0, 0);
    cfg(1, 0, 0, 0, 0, 0);
    cfg(3, 1, 1, 1, 0, 1);
    arm = 1'b1; fire = 1'b1; t = cyc;
    for (int k = 1; k <= 3; k++) begin
      sb_push(t + k, 0, 4'h8, 4'h0, "s3_no_pulse");
      sb_push(t + k, 2, 4'h1, 4'h0, "s3_busy_idle");
    end
    sb_push(t + 1, 1, 4'h8, 4'h0, "s3_armed_done");
    sb_push(t + 1, 1, 4'h1, 4'h1, "s3_disabled_stays");
    tick;
    arm = 1'b0; fire = 1'b0;
    tick;
    tick;
    arm = 1'b1; fire = 1'b1; t2 = cyc;
    sb_push(t2 + 1, 0, 4'h8, 4'h0, "s3_trig");
    sb_push(t2 + 2, 0, 4'h8, 4'h8, "s3_trig");
    sb_push(t2 + 3, 0, 4'h8, 4'h0, "s3_trig");
    sb_push(t2 + 2, 1, 4'h8, 4'h0, "s3_done");
    sb_push(t2 + 3, 1, 4'h8, 4'h8, "s3_done");
    sb_push(t2 + 1, 2, 4'h1, 4'h1, "s3_busy");
    sb_push(t2 + 3, 2, 4'h1, 4'h0, "s3_busy");
    tick;
    arm = 1'b0; fire = 1'b0;
    repeat (4) tick;
    // ch2 rest=1: hard_stop together with rst mid-pulse, then replay retained config
    cfg(3, 0, 0, 0, 0, 0);
    cfg(2, 1, 0, 6, 0, 1);
    arm = 1'b1;
    tick;
    fire = 1'b1; t = cyc;
    for (int k = 1; k <= 3; k++) sb_push(t + k, 0, 4'h4, 4'h0, "s4_active");
    sb_push(t + 2, 2, 4'h1, 4'h1, "s4_busy");
    sb_push(t + 4, 0, 4'h4, 4'h4, "s4_stop_trig");
    sb_push(t + 4, 1, 4'h4, 4'h4, "s4_stop_done");
    sb_push(t + 4, 2, 4'h1, 4'h0, "s4_stop_busy");
    tick;
    arm = 1'b0; fire = 1'b0;
    tick;
    tick;
    hard_stop = 1'b1; rst = 1'b0;
    tick;
    hard_stop = 1'b0; rst = 1'b1;
    tick;
    arm = 1'b1;
    tick;
    fire = 1'b1; t = cyc;
    for (int k = 1; k <= 7; k++) sb_push(t + k, 0, 4'h4, k == 7 ? 4'h4 : 4'h0, "s4_replay_trig");
    sb_push(t + 6, 1, 4'h4, 4'h0, "s4_replay_done");
    sb_push(t + 7, 1, 4'h4, 4'h4, "s4_replay_done");
    tick;
    arm = 1'b0; fire = 1'b0;
    repeat (8) tick;
    // ch1 reconfigured, then written while running and an out-of-range write on the 3-channel bank
    cfg(2, 0, 0, 0, 0, 0);
    cfg(1, 1, 2, 3, 2, 2);
    arm = 1'b1;
    tick;
    fire = 1'b1; t = cyc;
    for (int k = 1; k <= 12; k++)
      sb_push(t + k, 0, 4'h2, ((k >= 3 && k <= 5) || (k >= 8 && k <= 10)) ? 4'h2 : 4'h0, "s5_trig");
    sb_push(t + 10, 1, 4'h2, 4'h0, "s5_done");
    sb_push(t + 11, 1, 4'h2, 4'h2, "s5_done");
    tick;
    arm = 1'b0; fire = 1'b0;
    cfg(1, 1, 0, 1, 0, 5);
    cfg_ch = 2'd3; cfg_en = 1'b1; cfg_delay = '0; cfg_dur = 11'd5; cfg_npulse = 8'd1; cfg_wr3 = 1'b1;
    tick;
    cfg_wr3 = 1'b0;
    while (cyc < t + 13) tick;
    // rerun ch1 with unchanged shadows, reset lands in the first gap
    arm = 1'b1;
    tick;
    fire = 1'b1; t = cyc;
    for (int k = 1; k <= 6; k++) begin
      sb_push(t + k, 0, 4'h2, (k >= 3 && k <= 5) ? 4'h2 : 4'h0, "s6_trig");
      sb_push(t + k, 2, 4'h1, 4'h1, "s6_busy");
      sb_push(t + k, 3, 4'h7, 4'h7, "s6_oob_done3");
      sb_push(t + k, 4, 4'h1, 4'h0, "s6_oob_busy3");
    end
    sb_push(t + 7, 0, 4'hF, 4'b0100, "s6_rst_trig");
    sb_push(t + 7, 1, 4'hF, 4'hF, "s6_rst_done");
    sb_push(t + 7, 2, 4'h1, 4'h0, "s6_rst_busy");
    tick;
    arm = 1'b0; fire = 1'b0;
    while (cyc < t + 6) tick;
    rst = 1'b0;
    tick;
    rst = 1'b1;
    rest_level = 4'b0101; arm = 1'b1; fire = 1'b1; t = cyc;
    sb_push(t + 1, 0, 4'hF, 4'b0101, "idle_follow_rest");
    sb_push(t + 2, 1, 4'hF, 4'hF, "post_rst_disabled");
    sb_push(t + 1, 2, 4'h1, 4'h0, "post_rst_busy");
    sb_push(t + 2, 2, 4'h1, 4'h0, "post_rst_busy");
    tick;
    tick;
    arm = 1'b0; fire = 1'b0;
    repeat (3) tick;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/trigger_pulse_bank.md
TRIGGER_PULSE_BANK -- requirements
Module: trigger_pulse_bank

Interface
REQ-001 Parameters SHALL be:
- NCH, 4: channel count.
- DEL_W, 21: delay counter width.
- DUR_W, 11: pulse-duration and gap counter width.
- REP_W, 8: pulse-count width.
REQ-002 Ports SHALL be:
- clk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  synchronous, active-low reset.
- hard_stop  in  1  immediate abort, all channels.
- arm  in  1  arm request (onYourMark).
- fire  in  1  start request (GO).
- rest_level  in  NCH  per-channel idle output level.
- cfg_wr  in  1  configuration write strobe.
- cfg_ch  in  clog2(NCH)  target channel.
- cfg_en  in  1  channel enable.
- cfg_delay  in  DEL_W  cycles from fire to first pulse.
- cfg_dur  in  DUR_W  pulse width in cycles.
- cfg_gap  in  DUR_W  rest cycles between pulses.
- cfg_npulse  in  REP_W  pulse count.
- trig_out  out  NCH  trigger/LED outputs.
- ch_done  out  NCH  per-channel complete flag.
- busy  out  1  OR of channels in DELAY/ACTIVE/GAP.

Function
REQ-003 Each channel SHALL hold shadow registers (en, delay, dur, gap, npulse), written on cfg_wr only while that channel is IDLE or DONE; writes with cfg_ch>=NCH or to a running channel SHALL be ignored.
REQ-004 Each channel SHALL implement the states IDLE, ARMED, DELAY, ACTIVE, GAP and DONE.
REQ-005 Enabled IDLE/DONE channel with arm=1 SHALL go ARMED next cycle and clear ch_done; a disabled channel SHALL stay put.
REQ-006 ARMED channel with arm=1 and fire=1 SHALL copy shadows into working counters and enter DELAY; fire without arm, or fire to a non-ARMED channel, SHALL be ignored.
REQ-007 A channel in IDLE seeing arm=1 and fire=1 in the same cycle SHALL only reach ARMED; a second qualified fire is required.
REQ-008 DELAY SHALL decrement once per cycle; on zero, enter ACTIVE. The first pulse edge SHALL appear delay+1 cycles after the fire cycle (delay=0 gives 1 cycle).
REQ-009 ACTIVE SHALL drive trig_out to ~rest_level for exactly dur cycles. dur=0 SHALL produce no pulse but SHALL still count as one pulse.
REQ-010 After each pulse the pulse counter SHALL decrement. Nonzero remaining: GAP, holding rest_level for gap cycles (gap=0 gives back-to-back pulses merged high), then ACTIVE. Zero remaining: DONE.
REQ-011 npulse=0 SHALL be treated as 1.
REQ-012 DONE SHALL drive rest_level and ch_done=1, and hold until re-armed.
REQ-013 In IDLE, ARMED and DONE, trig_out SHALL follow rest_level with one-cycle latency, including mid-idle rest_level changes.
REQ-014 hard_stop=1 SHALL have priority over all other inputs including rst. Next cycle every channel SHALL be IDLE, trig_out=rest_level, ch_done=1 and working counters zero; shadows SHALL be retained.
REQ-015 Channels SHALL be fully independent except for the shared arm, fire and hard_stop inputs. Counters SHALL never wrap; all arithmetic is unsigned and saturates at zero.

Reset
REQ-016 With rst=0 at a clock edge and hard_stop=0, all channels SHALL go IDLE, shadows and counters SHALL be zero, trig_out=rest_level, ch_done all ones, and busy=0 on the next cycle.
REQ-017 Reset asserted mid-pulse SHALL return the output to rest_level on the next edge, with no partial-cycle glitch beyond registered timing.

Structure
REQ-018 Package trigger_pulse_pkg SHALL hold the channel-state enum and the default width constants.
REQ-019 The per-channel FSM and counters SHALL live in sub-module trigger_pulse_channel, instantiated NCH times by a generate loop. Top level SHALL hold only config decode and the busy OR.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Ch0 delay=3, dur=5, npulse=1, rest=0; arm, then fire at cycle T -> trig_out[0] high for cycles T+4..T+8; ch_done[0] rises at T+9.
- Ch1 dur=2, gap=3, npulse=3, delay=0 -> pattern 11000110001 1, starting T+1; then DONE.
- Arm and fire in the same cycle from IDLE -> state ARMED only, no pulse; a later fire starts the sequence.
- hard_stop mid-ACTIVE on ch2 (rest=1) -> trig_out[2]=1 and ch_done[2]=1 next cycle; re-arm replays the retained config.
- cfg_wr to a running channel and cfg_ch=NCH -> shadows unchanged; pulse timing unaffected.
- rst=0 mid-GAP with NCH=4 -> all outputs at rest_level, busy=0 next cycle.
